csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit.sv | 182 ++++++++++++++++++
 tb/tb_csr_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// Machine-mode CSR file: read/modify/write access, trap entry and return, counters, interrupt request.
// Reads and legality are combinational; all updates land on the next rising edge of clk.
module csr_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     CNT_W     = 64,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter logic [XLEN-1:0] HART_ID   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     csr_addr_i,
  input  logic [1:0]      csr_op_i,
  input  logic [XLEN-1:0] csr_wdata_i,
  output logic [XLEN-1:0] csr_rdata_o,
  output logic            csr_illegal_o,
  input  logic            instret_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic            irq_ext_i,
  input  logic            irq_tmr_i,
  input  logic            irq_sw_i,
  output logic            irq_req_o,
  output logic [XLEN-1:0] irq_cause_o,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mstatus_o
);

  localparam int unsigned EXT_W = (CNT_W > XLEN + 32) ? CNT_W : XLEN + 32;

  // Interrupt bit groups are stored packed as {bit11, bit7, bit3}.
  logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [2:0]      mie_q, mie_d, mip_q, mip_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d;
  logic [CNT_W-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

  logic [XLEN-1:0]  mstatus_rd, mie_rd, mip_rd, rd_val, wr_val;
  logic [EXT_W-1:0] mcycle_ext, minstret_ext, cyc_tmp, ins_tmp;
  logic             impl, ro, op_act, wr_req, wr_en;
  logic [2:0]       pend;
  logic [3:0]       code;

  assign mcycle_ext   = EXT_W'(mcycle_q);
  assign minstret_ext = EXT_W'(minstret_q);

  always_comb begin
    mstatus_rd     = '0;
    mstatus_rd[3]  = mst_mie_q;
    mstatus_rd[7]  = mst_mpie_q;
    mie_rd         = '0;
    mie_rd[3]      = mie_q[0];
    mie_rd[7]      = mie_q[1];
    mie_rd[11]     = mie_q[2];
    mip_rd         = '0;
    mip_rd[3]      = mip_q[0];
    mip_rd[7]      = mip_q[1];
    mip_rd[11]     = mip_q[2];
  end

  always_comb begin
    impl   = 1'b1;
    rd_val = '0;
    case (csr_addr_i)
      12'h300: rd_val = mstatus_rd;
      12'h304: rd_val = mie_rd;
      12'h305: rd_val = mtvec_q;
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'h344: rd_val = mip_rd;
      12'hB00: rd_val = mcycle_ext[XLEN-1:0];
      12'hB02: rd_val = minstret_ext[XLEN-1:0];
      12'hB80: if (XLEN == 32) rd_val = mcycle_ext[32 +: XLEN];   else impl = 1'b0;
      12'hB82: if (XLEN == 32) rd_val = minstret_ext[32 +: XLEN]; else impl = 1'b0;
      12'hF14: rd_val = HART_ID;
      default: impl = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read and never counts as a write.
  assign op_act        = csr_op_i != 2'b00;
  assign wr_req        = (csr_op_i == 2'b01) || (csr_op_i[1] && (|csr_wdata_i));
  assign ro            = (csr_addr_i[11:10] == 2'b11) || (csr_addr_i == 12'h344);
  assign csr_illegal_o = op_act && (!impl || (ro && wr_req));
  assign csr_rdata_o   = (op_act && impl) ? rd_val : '0;
  assign wr_en         = wr_req && !csr_illegal_o;

  always_comb begin
    case (csr_op_i)
      2'b01:   wr_val = csr_wdata_i;
      2'b10:   wr_val = rd_val | csr_wdata_i;
      2'b11:   wr_val = rd_val & ~csr_wdata_i;
      default: wr_val = rd_val;
    endcase
  end

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mip_d      = {irq_ext_i, irq_tmr_i, irq_sw_i};
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + CNT_W'(1);
    minstret_d = minstret_q + CNT_W'(instret_i);
    cyc_tmp    = mcycle_ext;
    ins_tmp    = minstret_ext;
    if (trap_i) begin
      mepc_d     = trap_pc_i & ~XLEN'(3);
      mcause_d   = trap_cause_i;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_i) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (wr_en) begin
      // A write to one counter half replaces the increment; the other half holds.
      case (csr_addr_i)
        12'h300: begin mst_mie_d = wr_val[3]; mst_mpie_d = wr_val[7]; end
        12'h304: mie_d      = {wr_val[11], wr_val[7], wr_val[3]};
        12'h305: mtvec_d    = wr_val;
        12'h340: mscratch_d = wr_val;
        12'h341: mepc_d     = wr_val & ~XLEN'(3);
        12'h342: mcause_d   = wr_val;
        12'hB00: begin cyc_tmp[XLEN-1:0]   = wr_val; mcycle_d   = CNT_W'(cyc_tmp); end
        12'hB02: begin ins_tmp[XLEN-1:0]   = wr_val; minstret_d = CNT_W'(ins_tmp); end
        12'hB80: begin cyc_tmp[32 +: XLEN] = wr_val; mcycle_d   = CNT_W'(cyc_tmp); end
        12'hB82: begin ins_tmp[32 +: XLEN] = wr_val; minstret_d = CNT_W'(ins_tmp); end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= '0;
      mip_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mip_q      <= mip_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // External beats software beats timer.
  assign pend      = mip_q & mie_q;
  assign irq_req_o = mst_mie_q && (|pend);
  assign code      = pend[2] ? 4'd11 : (pend[0] ? 4'd3 : 4'd7);

  always_comb begin
    irq_cause_o = '0;
    if (irq_req_o) begin
      irq_cause_o[XLEN-1] = 1'b1;
      irq_cause_o[3:0]    = code;
    end
  end

  assign mtvec_o   = mtvec_q;
  assign mepc_o    = mepc_q;
  assign mstatus_o = mstatus_rd;

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: vector table for single-cycle accesses plus trap, interrupt, counter and reset sequences.
module tb_csr_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_addr_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_wdata_i, csr_rdata_o;
  logic        csr_illegal_o;
  logic        instret_i, trap_i, mret_i;
  logic [31:0] trap_cause_i, trap_pc_i;
  logic        irq_ext_i, irq_tmr_i, irq_sw_i;
  logic        irq_req_o;
  logic [31:0] irq_cause_o, mtvec_o, mepc_o, mstatus_o;

  int total = 0;
  int bad   = 0;

  csr_unit #(
    .XLEN(32), .CNT_W(64), .MTVEC_RST(32'h0000_0100), .HART_ID(32'h0000_0005)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i), .csr_wdata_i(csr_wdata_i),
    .csr_rdata_o(csr_rdata_o), .csr_illegal_o(csr_illegal_o),
    .instret_i(instret_i), .trap_i(trap_i), .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i), .mret_i(mret_i),
    .irq_ext_i(irq_ext_i), .irq_tmr_i(irq_tmr_i), .irq_sw_i(irq_sw_i),
    .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mstatus_o(mstatus_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        ill;
  } vec_t;

  vec_t vt[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic acc(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    csr_op_i = op; csr_addr_i = addr; csr_wdata_i = wd;
  endtask

  initial begin
    vt[0]  = '{2'b01, 12'h340, 32'hA5A5_0000, 32'h0000_0000, 1'b1, 1'b0};
    vt[1]  = '{2'b10, 12'h340, 32'h0000_00FF, 32'hA5A5_0000, 1'b1, 1'b0};
    vt[2]  = '{2'b11, 12'h340, 32'hA500_0000, 32'hA5A5_00FF, 1'b1, 1'b0};
    vt[3]  = '{2'b10, 12'h340, 32'h0000_0000, 32'h00A5_00FF, 1'b1, 1'b0};
    vt[4]  = '{2'b01, 12'hF14, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
    vt[5]  = '{2'b10, 12'hF14, 32'h0000_0000, 32'h0000_0005, 1'b1, 1'b0};
    vt[6]  = '{2'b10, 12'h7C0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
    vt[7]  = '{2'b00, 12'h340, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vt[8]  = '{2'b01, 12'h344, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};
    vt[9]  = '{2'b11, 12'h344, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vt[10] = '{2'b01, 12'h305, 32'h0000_0200, 32'h0000_0100, 1'b1, 1'b0};
    vt[11] = '{2'b10, 12'h305, 32'h0000_0000, 32'h0000_0200, 1'b1, 1'b0};
    vt[12] = '{2'b01, 12'h341, 32'h0000_1237, 32'h0000_0000, 1'b1, 1'b0};
    vt[13] = '{2'b10, 12'h341, 32'h0000_0000, 32'h0000_1234, 1'b1, 1'b0};
    vt[14] = '{2'b01, 12'h300, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vt[15] = '{2'b10, 12'h300, 32'h0000_0000, 32'h0000_0088, 1'b1, 1'b0};
    vt[16] = '{2'b01, 12'h300, 32'h0000_0000, 32'h0000_0088, 1'b1, 1'b0};
    vt[17] = '{2'b01, 12'h304, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    vt[18] = '{2'b10, 12'h304, 32'h0000_0000, 32'h0000_0888, 1'b1, 1'b0};
    vt[19] = '{2'b01, 12'h304, 32'h0000_0000, 32'h0000_0888, 1'b1, 1'b0};
    vt[20] = '{2'b01, 12'h342, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0};
    vt[21] = '{2'b10, 12'h342, 32'h0000_0000, 32'h0000_0002, 1'b1, 1'b0};
    vt[22] = '{2'b01, 12'hB02, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
    vt[23] = '{2'b10, 12'hB02, 32'h0000_0000, 32'h0000_0005, 1'b1, 1'b0};
    vt[24] = '{2'b11, 12'hB82, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vt[25] = '{2'b10, 12'hF14, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1};

    rst_n = 1'b0;
    acc(2'b00, 12'h000, 32'h0);
    instret_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
    trap_cause_i = '0; trap_pc_i = '0;
    irq_ext_i = 1'b0; irq_tmr_i = 1'b0; irq_sw_i = 1'b0;
    #12;
    chk("rst_mtvec", mtvec_o, 32'h0000_0100);
    chk("rst_mstatus", mstatus_o, 32'h0);
    chk("rst_mepc", mepc_o, 32'h0);
    chk("rst_irq_req", {31'b0, irq_req_o}, 32'h0);
    chk("rst_irq_cause", irq_cause_o, 32'h0);

    // Release, then ten edges of counting.
    cyc();
    rst_n = 1'b1;
    repeat (10) cyc();
    acc(2'b10, 12'hB00, 32'h0); #1;
    chk("mcycle_10", csr_rdata_o, 32'd10);
    acc(2'b10, 12'hB80, 32'h0); #1;
    chk("mcycleh_0", csr_rdata_o, 32'd0);
    acc(2'b10, 12'hB02, 32'h0); #1;
    chk("minstret_0", csr_rdata_o, 32'd0);
    cyc();

    for (int i = 0; i < 26; i++) begin
      acc(vt[i].op, vt[i].addr, vt[i].wdata);
      #1;
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), csr_rdata_o, vt[i].rdata);
      chk($sformatf("vec%0d_illegal", i), {31'b0, csr_illegal_o}, {31'b0, vt[i].ill});
      cyc();
    end
    acc(2'b00, 12'h000, 32'h0); #1;
    chk("mtvec_out", mtvec_o, 32'h0000_0200);
    chk("mepc_out", mepc_o, 32'h0000_1234);

    // minstret counting, then a write that wins over the same-cycle increment.
    instret_i = 1'b1;
    repeat (3) cyc();
    instret_i = 1'b0;
    acc(2'b10, 12'hB02, 32'h0); #1;
    chk("minstret_8", csr_rdata_o, 32'd8);
    acc(2'b01, 12'hB02, 32'h100); instret_i = 1'b1;
    cyc();
    instret_i = 1'b0;
    acc(2'b10, 12'hB02, 32'h0); #1;
    chk("minstret_wr_prio", csr_rdata_o, 32'h100);
    cyc();

    // Interrupt raise, trap entry with a losing CSR write, return.
    acc(2'b01, 12'h300, 32'h8);
    cyc();
    acc(2'b01, 12'h304, 32'h800); irq_ext_i = 1'b1; #1;
    chk("irq_not_yet", {31'b0, irq_req_o}, 32'h0);
    cyc();
    acc(2'b00, 12'h000, 32'h0); #1;
    chk("irq_req_ext", {31'b0, irq_req_o}, 32'h1);
    chk("irq_cause_ext", irq_cause_o, 32'h8000_000B);
    trap_i = 1'b1; trap_cause_i = 32'h8000_000B; trap_pc_i = 32'h0000_1003;
    acc(2'b01, 12'h341, 32'hDEAD_BEEF);
    cyc();
    trap_i = 1'b0;
    acc(2'b10, 12'h342, 32'h0); #1;
    chk("trap_mepc", mepc_o, 32'h0000_1000);
    chk("trap_mstatus", mstatus_o, 32'h0000_0080);
    chk("trap_irq_req", {31'b0, irq_req_o}, 32'h0);
    chk("trap_irq_cause", irq_cause_o, 32'h0);
    chk("trap_mcause", csr_rdata_o, 32'h8000_000B);
    mret_i = 1'b1;
    acc(2'b01, 12'h300, 32'h0);
    cyc();
    mret_i = 1'b0;
    acc(2'b00, 12'h000, 32'h0); #1;
    chk("mret_mstatus", mstatus_o, 32'h0000_0088);
    chk("mret_irq_req", {31'b0, irq_req_o}, 32'h1);
    trap_i = 1'b1; mret_i = 1'b1; trap_cause_i = 32'h7; trap_pc_i = 32'h0000_2002;
    cyc();
    trap_i = 1'b0; mret_i = 1'b0; #1;
    chk("trap_over_mret_mstatus", mstatus_o, 32'h0000_0080);
    chk("trap_over_mret_mepc", mepc_o, 32'h0000_2000);

    // Interrupt priority: ext > sw > tmr.
    acc(2'b01, 12'h300, 32'h8);
    cyc();
    acc(2'b01, 12'h304, 32'h888); irq_sw_i = 1'b1; irq_tmr_i = 1'b1;
    cyc();
    acc(2'b00, 12'h000, 32'h0); #1;
    chk("prio_all", irq_cause_o, 32'h8000_000B);
    irq_ext_i = 1'b0;
    cyc();
    chk("prio_sw", irq_cause_o, 32'h8000_0003);
    irq_sw_i = 1'b0;
    cyc();
    chk("prio_tmr", irq_cause_o, 32'h8000_0007);
    irq_tmr_i = 1'b0;
    cyc();
    chk("prio_none_req", {31'b0, irq_req_o}, 32'h0);
    chk("prio_none_cause", irq_cause_o, 32'h0);

    // 64-bit counter wrap.
    acc(2'b01, 12'hB00, 32'hFFFF_FFFF);
    cyc();
    acc(2'b01, 12'hB80, 32'hFFFF_FFFF);
    cyc();
    acc(2'b10, 12'hB00, 32'h0); #1;
    chk("wrap_lo_ones", csr_rdata_o, 32'hFFFF_FFFF);
    acc(2'b10, 12'hB80, 32'h0); #1;
    chk("wrap_hi_ones", csr_rdata_o, 32'hFFFF_FFFF);
    cyc();
    acc(2'b10, 12'hB00, 32'h0); #1;
    chk("wrap_lo_zero", csr_rdata_o, 32'h0);
    acc(2'b10, 12'hB80, 32'h0); #1;
    chk("wrap_hi_zero", csr_rdata_o, 32'h0);

    // Reset asserted while a write is pending.
    acc(2'b01, 12'h340, 32'h0000_1234); #1;
    rst_n = 1'b0; #1;
    chk("rst_mid_mtvec", mtvec_o, 32'h0000_0100);
    cyc();
    rst_n = 1'b1;
    acc(2'b10, 12'h340, 32'h0); #1;
    chk("rst_mid_mscratch", csr_rdata_o, 32'h0);
    acc(2'b10, 12'hB00, 32'h0); #1;
    chk("rst_rel_mcycle0", csr_rdata_o, 32'h0);
    cyc();
    chk("rst_rel_mcycle1", csr_rdata_o, 32'h1);
    acc(2'b00, 12'h000, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
